// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: I-cache request/response, front-end redirect and fetch-buffer push.
interface inst_fetch_if #(
    parameter int unsigned FETCH_WIDTH = 4
);
    logic                      icache_req_valid;
    logic [31:0]               icache_req_addr;
    logic                      icache_req_ready;
    logic                      icache_resp_valid;
    logic [32*FETCH_WIDTH-1:0] icache_resp_data;
    logic                      redirect_valid;
    logic [31:0]               redirect_pc;
    logic                      fb_full;
    logic                      insts_out_valid;
    logic [32*FETCH_WIDTH-1:0] insts_out_inst;
    logic [32*FETCH_WIDTH-1:0] insts_out_pc;
    logic [FETCH_WIDTH-1:0]    insts_out_mask;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_ready, icache_resp_valid, icache_resp_data,
        input  redirect_valid, redirect_pc, fb_full,
        output insts_out_valid, insts_out_inst, insts_out_pc, insts_out_mask
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_ready, icache_resp_valid, icache_resp_data,
        output redirect_valid, redirect_pc, fb_full,
        input  insts_out_valid, insts_out_inst, insts_out_pc, insts_out_mask
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding I-cache request per packet, redirect handling,
// and a held packet register that pushes whole packets into the fetch buffer.
module inst_fetch #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
    input logic          clock,
    input logic          reset,
    inst_fetch_if.master bus
);
    localparam int unsigned BLK_BYTES = FETCH_WIDTH * 4;
    localparam int unsigned OFF_W     = $clog2(BLK_BYTES);
    localparam int unsigned PKT_W     = 32 * FETCH_WIDTH;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_PUSH, S_KILL} state_t;

    state_t                 state, state_nxt;
    logic [31:0]            pc, pc_nxt;
    logic [31:0]            aligned_pc;
    logic                   capture;
    logic                   push;
    logic [PKT_W-1:0]       pkt_inst;
    logic [PKT_W-1:0]       pkt_pc;
    logic [FETCH_WIDTH-1:0] pkt_mask;
    logic [PKT_W-1:0]       lane_pc;
    logic [FETCH_WIDTH-1:0] lane_mask;
    logic                   unused_redirect_lsb;

    assign aligned_pc          = {pc[31:OFF_W], OFF_W'(0)};
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    // Per-lane PCs and valid mask; lanes before an unaligned start PC are invalid.
    always_comb begin
        lane_pc   = '0;
        lane_mask = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            lane_pc[32*i +: 32] = aligned_pc + 32'(4 * i);
            lane_mask[i]        = OFF_W'(4 * i) >= pc[OFF_W-1:0];
        end
    end

    // Next-state, pc update and strobes; redirect overrides every other event.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        push      = 1'b0;
        case (state)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    state_nxt = bus.icache_req_ready ? S_KILL : S_REQ;
                end else if (bus.icache_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    state_nxt = bus.icache_resp_valid ? S_REQ : S_KILL;
                end else if (bus.icache_resp_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                if (bus.redirect_valid) begin
                    state_nxt = S_REQ;
                end else if (!bus.fb_full) begin
                    push      = 1'b1;
                    pc_nxt    = aligned_pc + 32'(BLK_BYTES);
                    state_nxt = S_REQ;
                end
            end
            S_KILL: begin
                // A response arriving alongside a redirect is still the one being
                // discarded; waiting for another would never end.
                if (bus.icache_resp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
        if (bus.redirect_valid) begin
            pc_nxt = {bus.redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            pkt_inst <= '0;
            pkt_pc   <= '0;
            pkt_mask <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                pkt_inst <= bus.icache_resp_data;
                pkt_pc   <= lane_pc;
                pkt_mask <= lane_mask;
            end
        end
    end

    assign bus.icache_req_valid = (state == S_REQ);
    assign bus.icache_req_addr  = aligned_pc;
    assign bus.insts_out_valid  = push;
    assign bus.insts_out_inst   = pkt_inst;
    assign bus.insts_out_pc     = pkt_pc;
    assign bus.insts_out_mask   = pkt_mask;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, back-pressure, redirects in every
// state, address wrap and mid-operation reset.
module tb_inst_fetch;
    localparam int unsigned FW = 4;
    localparam logic [127:0] PK1 = 128'hD003_0003_D002_0002_D001_0001_D000_0000;
    localparam logic [127:0] PK2 = 128'hE003_0003_E002_0002_E001_0001_E000_0000;

    logic        clock = 1'b0;
    logic        reset;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned push_cnt = 0;

    inst_fetch_if #(.FETCH_WIDTH(FW)) bus ();

    inst_fetch #(.FETCH_WIDTH(FW), .RESET_PC(32'h8000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset && bus.insts_out_valid) push_cnt <= push_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input logic [127:0] v, input int i);
        return v[32*i +: 32];
    endfunction

    // Advance to the next negedge with all handshake inputs back at idle.
    task automatic cyc();
        @(negedge clock);
        bus.icache_req_ready  = 1'b0;
        bus.icache_resp_valid = 1'b0;
        bus.redirect_valid    = 1'b0;
        bus.fb_full           = 1'b0;
    endtask

    // From REQ: accept, then return the packet 'lat' cycles after acceptance.
    task automatic do_fetch(input logic [127:0] data, input int lat);
        cyc();
        bus.icache_req_ready = 1'b1;
        for (int k = 1; k < lat; k++) cyc();
        cyc();
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = data;
    endtask

    initial begin
        reset                 = 1'b0;
        bus.icache_req_ready  = 1'b0;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_data  = '0;
        bus.redirect_valid    = 1'b0;
        bus.redirect_pc       = '0;
        bus.fb_full           = 1'b0;

        cyc();
        cyc(); #1;
        check("rst_out_valid", 32'(bus.insts_out_valid), 32'd0);
        check("rst_mask", 32'(bus.insts_out_mask), 32'd0);
        check("rst_req_valid", 32'(bus.icache_req_valid), 32'd1);
        check("rst_addr", bus.icache_req_addr, 32'h8000_0000);
        reset = 1'b1;

        // Sequential fetch, cache latency 2
        cyc(); bus.icache_req_ready = 1'b1; #1;
        check("s1_req_valid", 32'(bus.icache_req_valid), 32'd1);
        check("s1_addr", bus.icache_req_addr, 32'h8000_0000);
        cyc(); #1;
        check("s1_wait_noreq", 32'(bus.icache_req_valid), 32'd0);
        cyc(); bus.icache_resp_valid = 1'b1; bus.icache_resp_data = PK1; #1;
        check("s1_wait_nopush", 32'(bus.insts_out_valid), 32'd0);
        cyc(); #1;
        check("s1_push", 32'(bus.insts_out_valid), 32'd1);
        check("s1_mask", 32'(bus.insts_out_mask), 32'hF);
        check("s1_pc0", lane(bus.insts_out_pc, 0), 32'h8000_0000);
        check("s1_pc1", lane(bus.insts_out_pc, 1), 32'h8000_0004);
        check("s1_pc2", lane(bus.insts_out_pc, 2), 32'h8000_0008);
        check("s1_pc3", lane(bus.insts_out_pc, 3), 32'h8000_000C);
        check("s1_inst0", lane(bus.insts_out_inst, 0), 32'hD000_0000);
        cyc(); #1;
        check("s1_next_req", 32'(bus.icache_req_valid), 32'd1);
        check("s1_next_addr", bus.icache_req_addr, 32'h8000_0010);
        check("s1_push_once", push_cnt, 32'd1);

        // Fetch-buffer back-pressure for 5 cycles
        do_fetch(PK2, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(); bus.fb_full = 1'b1; #1;
            check("s2_hold_nopush", 32'(bus.insts_out_valid), 32'd0);
            check("s2_hold_pc0", lane(bus.insts_out_pc, 0), 32'h8000_0010);
            check("s2_hold_inst3", lane(bus.insts_out_inst, 3), 32'hE003_0003);
        end
        cyc(); #1;
        check("s2_push", 32'(bus.insts_out_valid), 32'd1);
        cyc(); #1;
        check("s2_push_once", push_cnt, 32'd2);
        check("s2_next_addr", bus.icache_req_addr, 32'h8000_0020);

        // Redirect in PUSH to an unaligned target
        do_fetch(PK1, 2);
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_010A; #1;
        check("s3_redir_nopush", 32'(bus.insts_out_valid), 32'd0);
        cyc(); #1;
        check("s3_req_valid", 32'(bus.icache_req_valid), 32'd1);
        check("s3_addr", bus.icache_req_addr, 32'h8000_0100);
        do_fetch(PK2, 2);
        cyc(); #1;
        check("s3_push", 32'(bus.insts_out_valid), 32'd1);
        check("s3_mask", 32'(bus.insts_out_mask), 32'hC);
        check("s3_pc2", lane(bus.insts_out_pc, 2), 32'h8000_0108);
        check("s3_pc3", lane(bus.insts_out_pc, 3), 32'h8000_010C);
        cyc(); #1;
        check("s3_next_addr", bus.icache_req_addr, 32'h8000_0110);
        check("s3_push_cnt", push_cnt, 32'd3);

        // Redirect in WAIT, response 3 cycles later is dropped
        cyc(); bus.icache_req_ready = 1'b1;
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0200; #1;
        check("s4_wait_noreq", 32'(bus.icache_req_valid), 32'd0);
        cyc(); #1;
        check("s4_kill_noreq", 32'(bus.icache_req_valid), 32'd0);
        check("s4_kill_nopush", 32'(bus.insts_out_valid), 32'd0);
        cyc();
        cyc(); bus.icache_resp_valid = 1'b1; bus.icache_resp_data = PK1;
        cyc(); #1;
        check("s4_req_valid", 32'(bus.icache_req_valid), 32'd1);
        check("s4_addr", bus.icache_req_addr, 32'h8000_0200);
        check("s4_nopush", 32'(bus.insts_out_valid), 32'd0);
        cyc(); #1;
        check("s4_push_cnt", push_cnt, 32'd3);

        // Redirect in REQ together with req_ready: accepted request is killed
        cyc(); bus.icache_req_ready = 1'b1; bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0300;
        cyc(); #1;
        check("s5_kill_noreq", 32'(bus.icache_req_valid), 32'd0);
        cyc(); bus.icache_resp_valid = 1'b1;
        cyc(); #1;
        check("s5_addr", bus.icache_req_addr, 32'h8000_0300);
        check("s5_req_valid", 32'(bus.icache_req_valid), 32'd1);

        // Redirect in WAIT with a same-cycle response goes straight to REQ
        bus.icache_req_ready = 1'b1;
        cyc(); bus.icache_resp_valid = 1'b1; bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0400;
        cyc(); #1;
        check("s6_req_valid", 32'(bus.icache_req_valid), 32'd1);
        check("s6_addr", bus.icache_req_addr, 32'h8000_0400);
        check("s6_nopush", 32'(bus.insts_out_valid), 32'd0);

        // Address wrap at the top of the address space
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF0;
        cyc(); #1;
        check("s7_addr", bus.icache_req_addr, 32'hFFFF_FFF0);
        do_fetch(PK2, 2);
        cyc(); #1;
        check("s7_push", 32'(bus.insts_out_valid), 32'd1);
        check("s7_mask", 32'(bus.insts_out_mask), 32'hF);
        check("s7_pc3", lane(bus.insts_out_pc, 3), 32'hFFFF_FFFC);
        cyc(); #1;
        check("s7_wrap_addr", bus.icache_req_addr, 32'h0000_0000);
        check("s7_push_cnt", push_cnt, 32'd4);

        // Reset while waiting on the cache
        cyc(); bus.icache_req_ready = 1'b1;
        cyc(); reset = 1'b0;
        cyc(); #1;
        check("s8_rst_nopush", 32'(bus.insts_out_valid), 32'd0);
        check("s8_rst_mask", 32'(bus.insts_out_mask), 32'd0);
        check("s8_rst_pc0", lane(bus.insts_out_pc, 0), 32'd0);
        reset = 1'b1;
        cyc(); #1;
        check("s8_req_valid", 32'(bus.icache_req_valid), 32'd1);
        check("s8_addr", bus.icache_req_addr, 32'h8000_0000);
        check("s8_push_cnt", push_cnt, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 4, instructions per fetch packet (power of two).
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 icache_req_valid  output  1  fetch request to I-cache.
REQ-007 icache_req_addr  output  32  packet-aligned fetch address.
REQ-008 icache_req_ready  input  1  I-cache accepts request.
REQ-009 icache_resp_valid  input  1  response data valid, one cycle.
REQ-010 icache_resp_data  input  32*FETCH_WIDTH  instruction words, lane 0 in bits [31:0].
REQ-011 redirect_valid  input  1  branch/exception redirect.
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 fb_full  input  1  fetch buffer full; push forbidden.
REQ-014 insts_out_valid  output  1  push strobe to fetch buffer (scalar, whole packet).
REQ-015 insts_out_inst  output  32*FETCH_WIDTH  packet instructions.
REQ-016 insts_out_pc  output  32*FETCH_WIDTH  per-lane PC.
REQ-017 insts_out_mask  output  FETCH_WIDTH  per-lane valid.

Function
REQ-018 SHALL implement states REQ, WAIT, PUSH, KILL; at most one outstanding cache request.
REQ-019 Block size B = FETCH_WIDTH*4 bytes; icache_req_addr SHALL equal pc with low log2(B) bits cleared.
REQ-020 REQ: icache_req_valid=1; on icache_req_ready -> WAIT; icache_req_valid SHALL be 0 in all other states.
REQ-021 WAIT: on icache_resp_valid, capture data, per-lane PCs (aligned+4*i) and mask into packet register -> PUSH.
REQ-022 Mask lane i SHALL be 1 iff aligned+4*i >= pc (lanes before an unaligned start PC invalid).
REQ-023 PUSH: insts_out_valid = ~fb_full; on push pc <= aligned+B (modulo 2^32) -> REQ; while fb_full=1 stay in PUSH, packet outputs held stable.
REQ-024 insts_out_valid SHALL be 0 outside PUSH and SHALL assert at most once per packet.
REQ-025 Redirect has priority over all other events; pc <= {redirect_pc[31:2], 2'b00}.
REQ-026 Redirect in REQ without req_ready, or in PUSH: no handshake/push that cycle, -> REQ.
REQ-027 Redirect in REQ with req_ready same cycle: request counts as accepted -> KILL.
REQ-028 Redirect in WAIT: with icache_resp_valid same cycle, drop response -> REQ; otherwise -> KILL.
REQ-029 KILL: discard next icache_resp_valid -> REQ; redirect in KILL updates pc, stays KILL.
REQ-030 Request-accept to push latency SHALL be cache latency + 1 cycle; push to next request 0 cycles (REQ entered the cycle after push).

Reset
REQ-031 reset=0 at a clock edge: state REQ, pc=RESET_PC, packet registers, mask and insts_out_valid 0; icache_req_valid=1 in the first cycle after release.
REQ-032 Reset mid-operation (any state) SHALL abandon the outstanding request and packet; I-cache shares reset, no stale response is expected.

Verification (FETCH_WIDTH=4, RESET_PC=0x8000_0000)
REQ-033 Release reset, req_ready=1, resp 2 cycles later, fb_full=0 -> req addr 0x8000_0000; one push, mask 4'b1111, PCs 0x8000_0000/04/08/0C; next req addr 0x8000_0010.
REQ-034 Redirect to 0x8000_010A in PUSH -> no push that cycle; next req addr 0x8000_0100; pushed mask 4'b1100, lane PCs 0x8000_0108, 0x8000_010C.
REQ-035 fb_full=1 for 5 cycles in PUSH -> insts_out_valid 0 and packet stable for 5 cycles; exactly one push on first cycle fb_full=0.
REQ-036 Redirect to 0x8000_0200 in WAIT, response 3 cycles later -> response discarded, no push; next req addr 0x8000_0200.
REQ-037 pc 0xFFFF_FFF0 packet pushed -> next req addr 0x0000_0000.
REQ-038 reset=0 during WAIT -> next cycle insts_out_valid 0, mask 0; after release req addr 0x8000_0000.
